// File: rtl/btn_pkg.sv
// -----------------------------------------------------------------------------
// btn_pkg
// Shared definitions for the push-button conditioner:
//   - btn_state_e : per-button debounce FSM states
//   - BTN_*       : bit index of each board button in the 5-bit output vectors
//   - cnt_width() : counter width large enough to hold the largest cycle count
// -----------------------------------------------------------------------------
package btn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } btn_state_e;

  localparam int NUM_BTNS = 5;
  localparam int BTN_C    = 4;
  localparam int BTN_L    = 3;
  localparam int BTN_R    = 2;
  localparam int BTN_U    = 1;
  localparam int BTN_D    = 0;

  // One spare bit above clog2 so a counter compared against the largest
  // parameter can reach it and still saturate without wrapping.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/btn_debounce_cell.sv
// -----------------------------------------------------------------------------
// btn_debounce_cell
// One button: 2-flop synchronizer, debounce FSM with a saturating stable-cycle
// counter, registered level / press / release outputs. With BTN_AUTOREPEAT_EN
// defined, a held button whose rpt_en_i is high also emits auto-repeat presses.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-low
//   raw_i      raw bouncing button, asynchronous to clk, active-high
//   rpt_en_i   allow auto-repeat for this button (only with BTN_AUTOREPEAT_EN)
//   level_o    debounced level
//   press_o    one-cycle pulse per accepted press or auto-repeat
//   release_o  one-cycle pulse per accepted release
//
// Configuration macro: BTN_AUTOREPEAT_EN
// -----------------------------------------------------------------------------
module btn_debounce_cell
  import btn_pkg::*;
#(
  parameter int DB_CYCLES     = 1000000,
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_PERIOD = 10000000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  input  logic rpt_en_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int CW = cnt_width(DB_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [CW-1:0] DB_CNT  = CW'(DB_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic          sync_meta_q, sync_q;
  btn_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_PERIOD - 1);

  // rpt_cnt_q counts HELD cycles since the last press pulse; rpt_periodic_q
  // selects between the initial delay and the repeat period.
  logic [CW-1:0] rpt_cnt_q, rpt_cnt_d;
  logic          rpt_periodic_q, rpt_periodic_d;
`else
  logic unused_rpt_en;
  assign unused_rpt_en = rpt_en_i;
`endif

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
    rpt_cnt_d      = rpt_cnt_q;
    rpt_periodic_d = rpt_periodic_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (sync_q) begin
          state_d = ST_PRESS_WAIT;
          cnt_d   = CNT_ONE;
        end
      end

      ST_PRESS_WAIT: begin
        if (!sync_q) begin
          state_d = ST_IDLE;  // bounce: drop silently
        end else if (cnt_q == DB_CNT) begin
          state_d = ST_HELD;
          press_d = 1'b1;
          level_d = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
          rpt_cnt_d      = '0;
          rpt_periodic_d = 1'b0;
`endif
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_HELD: begin
        if (!sync_q) begin
          state_d = ST_RELEASE_WAIT;
          cnt_d   = CNT_ONE;
        end
`ifdef BTN_AUTOREPEAT_EN
        else if (rpt_en_i) begin
          if (rpt_cnt_q == (rpt_periodic_q ? RP_LAST : RD_LAST)) begin
            press_d        = 1'b1;
            rpt_cnt_d      = '0;
            rpt_periodic_d = 1'b1;
          end else if (rpt_cnt_q != '1) begin
            rpt_cnt_d = rpt_cnt_q + CNT_ONE;
          end
        end
`endif
      end

      ST_RELEASE_WAIT: begin
        // Repeat counter is left untouched here, so a release bounce only
        // pauses auto-repeat instead of restarting its timing.
        if (sync_q) begin
          state_d = ST_HELD;
        end else if (cnt_q == DB_CNT) begin
          state_d   = ST_IDLE;
          release_d = 1'b1;
          level_d   = 1'b0;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_meta_q <= 1'b0;
      sync_q      <= 1'b0;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      rpt_cnt_q      <= '0;
      rpt_periodic_q <= 1'b0;
`endif
    end else begin
      sync_meta_q <= raw_i;
      sync_q      <= sync_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
`ifdef BTN_AUTOREPEAT_EN
      rpt_cnt_q      <= rpt_cnt_d;
      rpt_periodic_q <= rpt_periodic_d;
`endif
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/push_button_conditioner.sv
// -----------------------------------------------------------------------------
// push_button_conditioner
// Conditions the five board push-buttons {C,L,R,U,D} into debounced levels and
// one-cycle press / release pulses. Each button is an independent
// btn_debounce_cell; several buttons may pulse in the same cycle.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-low
//   C,L,R,U,D    raw bouncing buttons, asynchronous, active-high
//   btn_level    debounced levels,  bits {C,L,R,U,D} = [4:0]
//   btn_press    press / auto-repeat pulses, same order
//   btn_release  release pulses, same order
//   any_press    OR of btn_press in the same cycle
//
// Configuration macro: BTN_AUTOREPEAT_EN -- U and D auto-repeat while held.
// -----------------------------------------------------------------------------
module push_button_conditioner
  import btn_pkg::*;
#(
  parameter int DB_CYCLES     = 1000000,
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_PERIOD = 10000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                C,
  input  logic                L,
  input  logic                R,
  input  logic                U,
  input  logic                D,
  output logic [NUM_BTNS-1:0] btn_level,
  output logic [NUM_BTNS-1:0] btn_press,
  output logic [NUM_BTNS-1:0] btn_release,
  output logic                any_press
);

  logic [NUM_BTNS-1:0] raw;
  assign raw = {C, L, R, U, D};

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_cell
    btn_debounce_cell #(
      .DB_CYCLES     (DB_CYCLES),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_cell (
      .clk       (clk),
      .reset     (reset),
      .raw_i     (raw[i]),
      .rpt_en_i  ((i == BTN_U) || (i == BTN_D)),
      .level_o   (btn_level[i]),
      .press_o   (btn_press[i]),
      .release_o (btn_release[i])
    );
  end

  // Derived from registered pulses, so it is itself glitch-free and is
  // cleared by reset along with them.
  assign any_press = |btn_press;

endmodule

// File: tb/tb_push_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_push_button_conditioner
// Directed stimulus with DB_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
// Stimulus pushes the expected pulse (cycle, press, release, level) into a
// queue; a monitor pops an entry whenever the DUT shows a pulse and compares.
// Inputs change 2 time units after a rising edge (cycle n); the first edge
// that samples them is n+1 and the registered pulse appears at edge n+7,
// i.e. DB_CYCLES+2 cycles after the sampling edge.
// -----------------------------------------------------------------------------
module tb_push_button_conditioner;

  localparam int DB  = 4;
  localparam int RD  = 10;
  localparam int RP  = 3;
  localparam int LAT = DB + 3;

  typedef struct {
    int         cyc;
    logic [4:0] press;
    logic [4:0] rel;
    logic [4:0] level;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       C, L, R, U, D;
  logic [4:0] btn_level, btn_press, btn_release;
  logic       any_press;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  push_button_conditioner #(
    .DB_CYCLES     (DB),
    .REPEAT_DELAY  (RD),
    .REPEAT_PERIOD (RP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .C           (C),
    .L           (L),
    .R           (R),
    .U           (U),
    .D           (D),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .any_press   (any_press)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic expect_pulse(input int at, input logic [4:0] p, input logic [4:0] r,
                              input logic [4:0] lv);
    exp_t e;
    e.cyc = at; e.press = p; e.rel = r; e.level = lv;
    sb_q.push_back(e);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_level"},   32'(btn_level),   32'd0);
    check({tag, "_press"},   32'(btn_press),   32'd0);
    check({tag, "_release"}, 32'(btn_release), 32'd0);
    check({tag, "_any"},     32'(any_press),   32'd0);
  endtask

  // Monitor: every cycle with a pulse consumes one scoreboard entry.
  always @(negedge clk) begin
    if ((|btn_press) || (|btn_release)) begin
      if (sb_q.size() == 0) begin
        check("unexpected_pulse", {22'd0, btn_press, btn_release}, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("pulse_cycle", 32'(cyc),         32'(e.cyc));
        check("press",       32'(btn_press),   32'(e.press));
        check("release",     32'(btn_release), 32'(e.rel));
        check("level",       32'(btn_level),   32'(e.level));
        check("any_press",   32'(any_press),   32'(|e.press));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    {C, L, R, U, D} = 5'b0;
    tick(3);
    check_all_zero("reset");
    reset = 1'b1;
    tick(3);

    // Clean C press, held 20 cycles, then clean release.
    C = 1'b1;
    expect_pulse(cyc + LAT, 5'b10000, 5'b00000, 5'b10000);
    tick(20);
    C = 1'b0;
    expect_pulse(cyc + LAT, 5'b00000, 5'b10000, 5'b00000);
    tick(12);

    // L bounces: 3 high, 2 low, 3 high -- never accepted.
    L = 1'b1; tick(3);
    L = 1'b0; tick(2);
    L = 1'b1; tick(3);
    L = 1'b0; tick(10);
    check("l_glitch_level", 32'(btn_level), 32'd0);

    // U and D pressed in the same cycle, released together.
    U = 1'b1; D = 1'b1;
    expect_pulse(cyc + LAT, 5'b00011, 5'b00000, 5'b00011);
    tick(8);
    U = 1'b0; D = 1'b0;
    expect_pulse(cyc + LAT, 5'b00000, 5'b00011, 5'b00000);
    tick(12);

    // R press, then release with a 2-cycle low bounce, 1 high, clean low.
    R = 1'b1;
    expect_pulse(cyc + LAT, 5'b00100, 5'b00000, 5'b00100);
    tick(12);
    R = 1'b0; tick(2);
    R = 1'b1; tick(1);
    R = 1'b0;
    expect_pulse(cyc + LAT, 5'b00000, 5'b00100, 5'b00000);
    tick(12);

    // U and R held 30 cycles: R never repeats; U repeats only with the macro.
    begin
      int p;
      U = 1'b1; R = 1'b1;
      p = cyc + LAT;
      expect_pulse(p, 5'b00110, 5'b00000, 5'b00110);
`ifdef BTN_AUTOREPEAT_EN
      for (int k = RD; k <= 25; k += RP)
        expect_pulse(p + k, 5'b00010, 5'b00000, 5'b00110);
`endif
      tick(30);
      U = 1'b0; R = 1'b0;
      expect_pulse(cyc + LAT, 5'b00000, 5'b00110, 5'b00000);
      tick(12);
    end

    // Reset with C in HELD and L in PRESS_WAIT, both held through reset.
    C = 1'b1;
    expect_pulse(cyc + LAT, 5'b10000, 5'b00000, 5'b10000);
    tick(5);
    L = 1'b1;
    tick(4);
    reset = 1'b0;
    #1;
    check_all_zero("mid_reset");
    tick(3);
    reset = 1'b1;
    expect_pulse(cyc + LAT, 5'b11000, 5'b00000, 5'b11000);
    tick(10);
    C = 1'b0; L = 1'b0;
    expect_pulse(cyc + LAT, 5'b00000, 5'b11000, 5'b00000);
    tick(12);

    for (int i = 0; i < 100 && sb_q.size() != 0; i++) tick(1);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/push_button_conditioner.md
PUSH_BUTTON_CONDITIONER -- requirements
Module: push_button_conditioner

Interface
REQ-001 Parameter DB_CYCLES, default 1000000: consecutive stable synchronized cycles needed to accept a level change (10 ms at 100 MHz).
REQ-002 Parameter REPEAT_DELAY, default 50000000: cycles held after accepted press before first auto-repeat pulse.
REQ-003 Parameter REPEAT_PERIOD, default 10000000: cycles between subsequent auto-repeat pulses.
REQ-004 clk  input  1  system clock, 100 MHz, all logic on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 C, L, R, U, D  input  1 each  raw board push-buttons, asynchronous to clk, active-high, bouncing.
REQ-007 btn_level  output  5  debounced level, bit order {C,L,R,U,D} = bits [4:0].
REQ-008 btn_press  output  5  one-cycle pulse per accepted press or auto-repeat, same bit order.
REQ-009 btn_release  output  5  one-cycle pulse per accepted release, same bit order.
REQ-010 any_press  output  1  OR of btn_press, same cycle.

Function
REQ-011 Each raw input SHALL pass a 2-flop synchronizer before any other use.
REQ-012 Each button SHALL run an independent FSM: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
REQ-013 IDLE: synchronized 1 -> PRESS_WAIT, stable counter cleared to 1.
REQ-014 PRESS_WAIT: synchronized 0 -> IDLE (bounce rejected, no pulse); 1 with counter == DB_CYCLES -> HELD, else counter increments.
REQ-015 PRESS_WAIT->HELD SHALL assert btn_press for exactly that cycle and set btn_level to 1; pin-to-pulse latency DB_CYCLES+2 cycles for a clean edge.
REQ-016 HELD: synchronized 0 -> RELEASE_WAIT; symmetric rules to REQ-014 with return to HELD on bounce.
REQ-017 RELEASE_WAIT->IDLE SHALL assert btn_release for one cycle and clear btn_level.
REQ-018 Glitches shorter than DB_CYCLES cycles SHALL produce no pulse and no btn_level change.
REQ-019 Counters SHALL saturate, never wrap; width = clog2 of largest parameter + 1.
REQ-020 Buttons are independent; several btn_press bits MAY assert in the same cycle, none is dropped or prioritised.
REQ-021 btn_press and btn_release for one button SHALL never assert in the same cycle.

Reset
REQ-022 reset low SHALL force every FSM to IDLE, clear synchronizers, counters, btn_level, btn_press, btn_release, any_press to 0, asynchronously.
REQ-023 A button held through reset deassertion SHALL be treated as a new press (full DB_CYCLES qualification, then btn_press).

Configuration
REQ-024 Macro BTN_AUTOREPEAT_EN defined: U and D only SHALL auto-repeat while HELD: btn_press pulse after REPEAT_DELAY cycles in HELD, then every REPEAT_PERIOD cycles until leaving HELD.
REQ-025 Bounce into RELEASE_WAIT SHALL pause the repeat counter; return to HELD resumes it without reset.
REQ-026 Macro undefined: no repeat logic synthesized; exactly one btn_press per accepted press on all buttons.

Structure
REQ-027 Package btn_pkg SHALL hold the FSM state enum and bit-index constants BTN_C=4, BTN_L=3, BTN_R=2, BTN_U=1, BTN_D=0.
REQ-028 Sub-module btn_debounce_cell (synchronizer + FSM + counters, one button, repeat enable input) SHALL be instantiated five times.

Verification (DB_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
REQ-029 Clean C press held 20 cycles -> btn_press[4] single pulse 6 cycles after edge, btn_level[4]=1, any_press pulses same cycle.
REQ-030 L high 3 cycles, low 2, high 3 -> no btn_press, btn_level[3] stays 0.
REQ-031 U and D pressed same cycle -> btn_press[1:0]=2'b11 same cycle.
REQ-032 BTN_AUTOREPEAT_EN, U held 30 cycles -> press pulse, repeats at +10, +13, +16 ... cycles after it; R held equally -> single pulse.
REQ-033 Release of held R with 2-cycle bounce then clean low -> exactly one btn_release[2], level clears after 4 stable low cycles.
REQ-034 reset low mid-PRESS_WAIT and mid-HELD -> all outputs 0 immediately; held button re-qualified after reset high, one btn_press.
